// File: rtl/rv32i_types.sv
// Shared types for the write-result stage.
// Defines the CDB broadcast payload, the FU identifier and the arbiter defaults.
package rv32i_types;

    localparam int unsigned TOTAL_FU         = 6;
    localparam int unsigned FU_ID_W          = $clog2(TOTAL_FU);
    localparam int unsigned CDB_STARVE_LIMIT = 4;
    localparam int unsigned AGE_W            = 4;

    typedef logic [FU_ID_W-1:0] fu_id_t;

    typedef struct packed {
        fu_id_t       fu_id;
        logic [4:0]   rd;
        logic [31:0]  data;
        logic [63:0]  order;
    } cdb_entry_t;

endpackage

// File: rtl/rr_picker.sv
// N-way round-robin first-one finder.
// Scans from ptr upward, wrapping modulo N, and returns the first set bit.
module rr_picker #(
    parameter int unsigned N  = 6,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    always_comb begin
        int unsigned pos;
        logic [IW-1:0] j;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        j     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // N need not be a power of two, so the wrap is an explicit subtract
            pos = 32'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            j = IW'(pos);
            if (!found && req[j]) begin
                found    = 1'b1;
                idx      = j;
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Write-result arbiter: grants one finished FU per cycle and broadcasts its
// result on the CDB the following cycle, with round-robin plus starvation guard.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned NUM_FU       = TOTAL_FU,
    parameter int unsigned STARVE_LIMIT = CDB_STARVE_LIMIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [NUM_FU-1:0]      req_valid,
    input  logic [NUM_FU-1:0][4:0] req_rd,
    input  logic [NUM_FU-1:0][31:0] req_data,
    input  logic [NUM_FU-1:0][63:0] req_order,
    output logic [NUM_FU-1:0]      grant,
    output logic                   cdb_valid,
    output cdb_entry_t             cdb_data
);

    localparam int unsigned AGE_MAX = (1 << AGE_W) - 1;

    logic [AGE_W-1:0]  age [NUM_FU];
    fu_id_t            rr_ptr;
    fu_id_t            next_ptr;
    logic [NUM_FU-1:0] starve;
    logic [NUM_FU-1:0] starve_grant;
    logic [NUM_FU-1:0] rr_grant;
    fu_id_t            starve_idx;
    fu_id_t            rr_idx;
    fu_id_t            win_idx;
    logic              starve_found;
    logic              rr_found;
    logic              any_grant;
    cdb_entry_t        win_entry;

    always_comb begin
        starve = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            starve[i] = req_valid[i] && (age[i] >= AGE_W'(STARVE_LIMIT));
        end
    end

    // Starved requesters are served lowest index first, so this picker scans from 0
    rr_picker #(.N(NUM_FU), .IW(FU_ID_W)) u_starve_pick (
        .req   (starve),
        .ptr   ('0),
        .grant (starve_grant),
        .idx   (starve_idx),
        .found (starve_found)
    );

    rr_picker #(.N(NUM_FU), .IW(FU_ID_W)) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .idx   (rr_idx),
        .found (rr_found)
    );

    // Grant is suppressed while in reset and during a flush cycle
    always_comb begin
        grant   = '0;
        win_idx = '0;
        if (rst && !flush) begin
            if (starve_found) begin
                grant   = starve_grant;
                win_idx = starve_idx;
            end else if (rr_found) begin
                grant   = rr_grant;
                win_idx = rr_idx;
            end
        end
    end

    assign any_grant = |grant;
    assign next_ptr  = (win_idx == fu_id_t'(NUM_FU - 1)) ? '0 : win_idx + fu_id_t'(1);

    always_comb begin
        win_entry       = '0;
        win_entry.fu_id = win_idx;
        win_entry.rd    = req_rd[win_idx];
        win_entry.data  = req_data[win_idx];
        win_entry.order = req_order[win_idx];
    end

    // CDB broadcast register and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            cdb_valid <= any_grant;
            if (any_grant) begin
                cdb_data <= win_entry;
                rr_ptr   <= next_ptr;
            end
        end
    end

    // Per-FU wait counters, saturating at the top of their range
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (flush || !req_valid[i] || grant[i]) begin
                    age[i] <= '0;
                end else if (age[i] != AGE_W'(AGE_MAX)) begin
                    age[i] <= age[i] + AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Write-Result stage of the scoreboard pipeline. Sits directly downstream of the functional units and feeds the scoreboard, the register file and every waiting FU.
- Arbitrates among FUs that have a finished result. Grants one FU per cycle and broadcasts the winner's result on the Common Data Bus (CDB) one cycle later, from registers.
- Round-robin priority, plus a starvation guard that forces service of any requester that has waited STARVE_LIMIT cycles.

Parameters:
- NUM_FU, default TOTAL_FU (package constant): number of requesting functional units.
- STARVE_LIMIT, default 4: consecutive lost-arbitration cycles after which a requester gets forced priority. Range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- flush  in  1  global flush from branch mispredict.
- req_valid  in  NUM_FU  FU i has a completed result pending.
- req_rd  in  NUM_FU x 5  destination register of FU i.
- req_data  in  NUM_FU x 32  result value of FU i.
- req_order  in  NUM_FU x 64  retire order tag of FU i.
- grant  out  NUM_FU  one-hot or zero; FU i's result is accepted this cycle.
- cdb_valid  out  1  CDB carries a valid broadcast.
- cdb_data  out  cdb_entry_t  {fu_id, rd, data, order} of the broadcast.

Behaviour:
- Reset (rst=0, asynchronous):
  - cdb_valid=0, cdb_data='0.
  - rr_ptr=0; all age counters=0.
  - grant=0 while rst=0.
- Handshake:
  - FU raises req_valid and holds req_rd/req_data/req_order stable until it sees grant[i]=1.
  - grant is combinational in the same cycle. The FU drops or replaces its request the next cycle and drives complete_valid in the granted cycle.
  - A request must never be withdrawn without a grant, except on flush.
- Arbitration (combinational, flush=0):
  - Starve set S = {i : req_valid[i] && age[i] >= STARVE_LIMIT}.
  - If S is non-empty, the winner is the lowest index in S.
  - Otherwise the winner is the first requester found scanning from rr_ptr upward, wrapping modulo NUM_FU.
  - No requests means grant=0.
- Latency: request granted in cycle N; cdb_valid=1 with the winner's fields in cycle N+1, for exactly one cycle per grant.
- CDB register, each edge:
  - cdb_valid <= (any grant).
  - cdb_data <= winner fields, with fu_id = winner index. When nothing is granted, cdb_data holds its previous value.
- rr_ptr: on a grant, rr_ptr <= (winner+1) mod NUM_FU. Unchanged when there is no grant.
- Age counters, per i:
  - 0 if !req_valid[i] or grant[i].
  - Otherwise incremented, saturating at 15.
- Full load: with all NUM_FU requesting continuously, each FU is granted exactly once per NUM_FU cycles.
- Flush:
  - grant=0 in the flush cycle, regardless of requests.
  - Next edge: cdb_valid<=0, age counters<=0, rr_ptr<=0.
  - A CDB broadcast already registered before the flush edge is visible for the flush cycle only.
- Simultaneous flush and rst=0: reset dominates.
- Reset asserted mid-broadcast: cdb_valid drops immediately, asynchronously.
- Width rules:
  - fu_id width equals that of fu_id_t.
  - Index arithmetic is modulo NUM_FU; NUM_FU need not be a power of two, so the wrap is handled explicitly.

Decomposition:
- rv32i_types package holds: cdb_entry_t {fu_id_t fu_id; logic [4:0] rd; logic [31:0] data; logic [63:0] order}, fu_id_t, TOTAL_FU, and the CDB_STARVE_LIMIT default.
- One natural sub-module, rr_picker: a parameterised N-way round-robin first-one finder (inputs req vector and pointer; outputs one-hot grant and index). It is instantiated twice: once with pointer 0 for the starve set, once with rr_ptr.
- Age counters and the CDB register stay in cdb_arbiter.

Test Plan:
- Single request: req_valid[2]=1, rd=5, data=0xDEADBEEF → grant=0b000100 same cycle; next cycle cdb_valid=1, fu_id=2, rd=5, data=0xDEADBEEF; the following cycle cdb_valid=0.
- Round-robin with NUM_FU=6: FUs 0, 1 and 4 request continuously from rr_ptr=0 → grant order 0, 1, 4, 0, 1, 4; rr_ptr sequence 1, 2, 5, 1, 2, 5.
- Starvation with STARVE_LIMIT=2: FUs 0 and 1 request continuously, FU 3 requests from cycle 0 with rr_ptr held favouring 0/1 → FU 3 is forced on the cycle its age reaches 2 and granted before either 0 or 1 repeats; age[3] returns to 0.
- Flush: FUs 1 and 3 request in the same cycle flush=1 → grant=0; next cycle cdb_valid=0, rr_ptr=0, all ages=0; the held requests are not granted until re-presented after flush.
- Async reset mid-traffic: rst pulled low between edges while cdb_valid=1 → cdb_valid=0 immediately without waiting for a clock edge. After rst=1, the first grant goes to the lowest requesting index.
- Wrap: rr_ptr=5 (NUM_FU=6), FUs 0 and 5 request → FU 5 granted, rr_ptr becomes 0; next cycle FU 0 granted.
